// File: rtl/id_decode_stage_pkg.sv
// Shared RV32I decode constants: ALU operation codes, base opcodes, operand selects
// and the decoded bundle carried from the decoder into the ID/EX register.
package id_decode_stage_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;
    localparam logic [4:0] ALU_JALR = 5'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic SRC0_RS1 = 1'b0;
    localparam logic SRC0_PC  = 1'b1;
    localparam logic SRC1_RS2 = 1'b0;
    localparam logic SRC1_IMM = 1'b1;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic        src0_sel;
        logic        src1_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic        illegal;
    } dec_bundle_t;

    // alt selects SUB/SRA over ADD/SRL (funct7[5])
    function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_decode_stage_inst_decoder.sv
// Combinational RV32I decoder: instruction word -> ALU op, operand selects,
// immediate, register indices, write enable and illegal flag.
module inst_decoder
    import id_decode_stage_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_bundle_t dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        wr;
    logic        illegal;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign rd     = inst_i[11:7];

    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_sh = {27'b0, inst_i[24:20]};

    always_comb begin
        dec_o          = '0;
        dec_o.alu_op   = ALU_ADD;
        dec_o.src0_sel = SRC0_RS1;
        dec_o.src1_sel = SRC1_RS2;
        dec_o.rs1      = inst_i[19:15];
        dec_o.rs2      = inst_i[24:20];
        dec_o.rd       = rd;
        wr             = 1'b0;
        illegal        = 1'b0;

        case (opcode)
            OPC_OP: begin
                wr           = 1'b1;
                dec_o.alu_op = arith_op(f3, f7[5]);
                illegal      = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
            end
            OPC_OP_IMM: begin
                wr             = 1'b1;
                dec_o.src1_sel = SRC1_IMM;
                if (f3 == F3_SLL || f3 == F3_SR) begin
                    dec_o.alu_op = arith_op(f3, f7[5]);
                    dec_o.imm    = imm_sh;
                    illegal      = !(f7 == F7_BASE || (f3 == F3_SR && f7 == F7_ALT));
                end else begin
                    dec_o.alu_op = arith_op(f3, 1'b0);
                    dec_o.imm    = imm_i;
                end
            end
            OPC_LUI: begin
                wr             = 1'b1;
                dec_o.alu_op   = ALU_LUI;
                dec_o.src1_sel = SRC1_IMM;
                dec_o.imm      = imm_u;
            end
            OPC_AUIPC: begin
                wr             = 1'b1;
                dec_o.src0_sel = SRC0_PC;
                dec_o.src1_sel = SRC1_IMM;
                dec_o.imm      = imm_u;
            end
            OPC_JAL: begin
                wr             = 1'b1;
                dec_o.src0_sel = SRC0_PC;
                dec_o.src1_sel = SRC1_IMM;
                dec_o.imm      = imm_j;
            end
            OPC_JALR: begin
                wr             = 1'b1;
                dec_o.alu_op   = ALU_JALR;
                dec_o.src1_sel = SRC1_IMM;
                dec_o.imm      = imm_i;
                illegal        = (f3 != 3'b000);
            end
            OPC_LOAD: begin
                wr             = 1'b1;
                dec_o.src1_sel = SRC1_IMM;
                dec_o.imm      = imm_i;
                illegal        = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OPC_STORE: begin
                dec_o.src1_sel = SRC1_IMM;
                dec_o.imm      = imm_s;
                illegal        = (f3[2] || f3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec_o.imm = imm_b;
                case (f3[2:1])
                    2'b00:   dec_o.alu_op = ALU_SUB;
                    2'b10:   dec_o.alu_op = ALU_SLT;
                    2'b11:   dec_o.alu_op = ALU_SLTU;
                    default: illegal      = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        // Unsupported encodings collapse to a harmless ADD that writes nothing
        if (illegal) begin
            dec_o.alu_op   = ALU_ADD;
            dec_o.src0_sel = SRC0_RS1;
            dec_o.src1_sel = SRC1_RS2;
            dec_o.imm      = '0;
            wr             = 1'b0;
        end

        dec_o.rf_we   = wr && (rd != 5'd0);
        dec_o.illegal = illegal;
    end

endmodule

// File: rtl/id_decode_stage.sv
// Single-entry ID/EX register around inst_decoder with valid/ready handshake and flush.
// Define ID_ILLEGAL_DET_EN to report unsupported encodings on out_illegal; otherwise it is tied 0.
module id_decode_stage
    import id_decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_alu_op,
    output logic        out_src0_sel,
    output logic        out_src1_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_rf_we,
    output logic        out_illegal
);

    dec_bundle_t dec;
    dec_bundle_t bundle_d, bundle_q;
    logic [31:0] pc_d, pc_q;
    logic        valid_d, valid_q;
    logic        accept;

    inst_decoder u_inst_decoder (
        .inst_i (in_inst),
        .dec_o  (dec)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        pc_d     = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            pc_d     = in_pc;
`ifdef ID_ILLEGAL_DET_EN
            bundle_d.illegal = dec.illegal;
`else
            bundle_d.illegal = 1'b0;
`endif
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_alu_op   = bundle_q.alu_op;
    assign out_src0_sel = bundle_q.src0_sel;
    assign out_src1_sel = bundle_q.src1_sel;
    assign out_imm      = bundle_q.imm;
    assign out_rs1      = bundle_q.rs1;
    assign out_rs2      = bundle_q.rs2;
    assign out_rd       = bundle_q.rd;
    assign out_rf_we    = bundle_q.rf_we;
    assign out_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed vectors plus randomized traffic against a
// table-driven RV32I reference model and a one-entry handshake model.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_alu_op;
    logic        out_src0_sel;
    logic        out_src1_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rf_we;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    logic        m_valid = 1'b0;
    logic [87:0] m_bun = '0;
    logic [87:0] obs_bun;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_alu_op   (out_alu_op),
        .out_src0_sel (out_src0_sel),
        .out_src1_sel (out_src1_sel),
        .out_imm      (out_imm),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_rf_we    (out_rf_we),
        .out_illegal  (out_illegal)
    );

    assign obs_bun = {out_pc, out_alu_op, out_src0_sel, out_src1_sel, out_imm,
                      out_rs1, out_rs2, out_rd, out_rf_we, out_illegal};

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode, written as lookup tables over funct3 plus legality masks.
    function automatic logic [87:0] ref_dec(input logic [31:0] i, input logic [31:0] pc);
        int          arith [8];
        int          br [8];
        logic [7:0]  load_ok, store_ok;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        int          op;
        logic        s0, s1, we, ill, ill_out;
        logic [31:0] imm;
        arith    = '{0, 5, 8, 9, 4, 6, 3, 2};
        br       = '{1, 1, -1, -1, 8, 8, 9, 9};
        load_ok  = 8'b0011_0111;
        store_ok = 8'b0000_0111;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        op = 0; s0 = 0; s1 = 0; we = 0; ill = 0; imm = 0;
        if (opc == 7'h33) begin
            op  = arith[f3] + ((f7 == 7'h20) ? 1 : 0);
            we  = 1;
            ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        end else if (opc == 7'h13) begin
            s1 = 1; we = 1;
            if (f3 == 1 || f3 == 5) begin
                op  = arith[f3] + ((f7 == 7'h20) ? 1 : 0);
                imm = 32'(i[24:20]);
                ill = !(f7 == 0 || (f3 == 5 && f7 == 7'h20));
            end else begin
                op  = arith[f3];
                imm = 32'($signed(i) >>> 20);
            end
        end else if (opc == 7'h37) begin
            op = 10; s1 = 1; we = 1; imm = i & 32'hFFFF_F000;
        end else if (opc == 7'h17) begin
            s0 = 1; s1 = 1; we = 1; imm = i & 32'hFFFF_F000;
        end else if (opc == 7'h6F) begin
            s0 = 1; s1 = 1; we = 1;
            imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        end else if (opc == 7'h67) begin
            op = 11; s1 = 1; we = 1; imm = 32'($signed(i) >>> 20);
            ill = (f3 != 0);
        end else if (opc == 7'h03) begin
            s1 = 1; we = 1; imm = 32'($signed(i) >>> 20);
            ill = !load_ok[f3];
        end else if (opc == 7'h23) begin
            s1 = 1; imm = 32'($signed({i[31:25], i[11:7]}));
            ill = !store_ok[f3];
        end else if (opc == 7'h63) begin
            op  = br[f3];
            imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            ill = (op < 0);
        end else begin
            ill = 1;
        end
        if (ill) begin
            op = 0; s0 = 0; s1 = 0; we = 0; imm = 0;
        end
        if (i[11:7] == 0) we = 0;
`ifdef ID_ILLEGAL_DET_EN
        ill_out = ill;
`else
        ill_out = 1'b0;
`endif
        return {pc, 5'(op), s0, s1, imm, i[19:15], i[24:20], i[11:7], we, ill_out};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [11];
        logic [31:0] w;
        int          k;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h0F, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = opcs[k];
        k = $urandom_range(0, 3);
        if (k == 0) w[31:25] = 7'h00;
        else if (k == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    // Called at a falling edge: drive, check in_ready, advance model, check outputs next falling edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic exp_rdy;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !m_valid || ordy;
        chk("in_ready", 96'(in_ready), 96'(exp_rdy));
        if (fl) m_valid = 1'b0;
        else if (v && exp_rdy) begin
            m_valid = 1'b1;
            m_bun   = ref_dec(inst, pc);
        end else if (ordy) m_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 96'(out_valid), 96'(m_valid));
        chk("bundle", 96'(obs_bun), 96'(m_bun));
    endtask

    initial begin
        #2;
        chk("rst_valid", 96'(out_valid), 96'(0));
        chk("rst_bundle", 96'(obs_bun), 96'(0));
        chk("rst_in_ready", 96'(in_ready), 96'(1));
        @(negedge clk);
        rstn = 1'b1;

        step(1, 32'h402081B3, 32'h100, 1, 0);
        chk("sub_op", 96'(out_alu_op), 96'(1));
        chk("sub_regs", 96'({out_rs1, out_rs2, out_rd}), 96'({5'd1, 5'd2, 5'd3}));
        chk("sub_we_sel", 96'({out_rf_we, out_src0_sel, out_src1_sel}), 96'(3'b100));

        step(1, 32'hFFF00293, 32'h104, 1, 0);
        chk("addi_op", 96'(out_alu_op), 96'(0));
        chk("addi_imm", 96'(out_imm), 96'(32'hFFFF_FFFF));
        chk("addi_sel_rd", 96'({out_src1_sel, out_rd}), 96'({1'b1, 5'd5}));

        step(1, 32'h123450B7, 32'h108, 1, 0);
        chk("lui_op", 96'(out_alu_op), 96'(10));
        chk("lui_imm", 96'(out_imm), 96'(32'h1234_5000));
        step(1, 32'h4030D113, 32'h10C, 1, 0);
        chk("srai_op", 96'(out_alu_op), 96'(7));
        chk("srai_imm", 96'(out_imm), 96'(3));

        // Stall three cycles with flush in the second, then a fresh capture
        step(1, 32'h00C58533, 32'h200, 1, 0);
        step(1, 32'h40B50533, 32'h204, 0, 0);
        chk("stall_pc", 96'(out_pc), 96'(32'h200));
        step(1, 32'h00000513, 32'h208, 0, 1);
        chk("flush_valid", 96'(out_valid), 96'(0));
        chk("flush_pc_held", 96'(out_pc), 96'(32'h200));
        step(1, 32'h00000000, 32'h20C, 0, 0);
        chk("zero_we", 96'(out_rf_we), 96'(0));
`ifdef ID_ILLEGAL_DET_EN
        chk("zero_illegal", 96'(out_illegal), 96'(1));
`else
        chk("zero_illegal", 96'(out_illegal), 96'(0));
`endif

        // Asynchronous reset while the bundle is stalled
        step(1, 32'h0FF00093, 32'h210, 0, 0);
        chk("pre_rst_valid", 96'(out_valid), 96'(1));
        #2;
        rstn = 1'b0;
        #1;
        m_valid = 1'b0;
        m_bun   = '0;
        chk("arst_valid", 96'(out_valid), 96'(0));
        chk("arst_in_ready", 96'(in_ready), 96'(1));
        chk("arst_bundle", 96'(obs_bun), 96'(0));
        @(negedge clk);
        rstn = 1'b1;
        step(0, 32'h402081B3, 32'h300, 0, 0);
        step(0, 32'h402081B3, 32'h304, 1, 0);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 9) < 7), rand_inst(), $urandom,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
